// File: rtl/axis_frame_mux.sv
// Two-source stream mux: round-robin grant held for a whole line (up to eol), output through a 2-entry skid buffer.
// Optional macro AXIS_MUX_FRAME_LOCK_EN holds the grant for LINES lines (one frame) instead of one.
module axis_frame_mux #(
  parameter int DATA_W = 16,
  parameter int LINES  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] s0_data_i,
  input  logic              s0_sof_i,
  input  logic              s0_eol_i,
  input  logic              s0_valid_i,
  output logic              s0_ready_o,
  input  logic [DATA_W-1:0] s1_data_i,
  input  logic              s1_sof_i,
  input  logic              s1_eol_i,
  input  logic              s1_valid_i,
  output logic              s1_ready_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_sof_o,
  output logic              m_eol_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              sel_o
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  localparam int BW = DATA_W + 2;

  state_t        state_q;
  logic          rr_q;
  logic          sel_q;
  logic          s0_ready_q;
  logic          s1_ready_q;
  logic [1:0]    cnt_q;
  logic [1:0]    cnt_d;
  logic [BW-1:0] head_q;
  logic [BW-1:0] tail_q;
  logic [BW-1:0] in_beat;
  logic          push0;
  logic          push1;
  logic          push;
  logic          pop;
  logic          in_eol;
  logic          last_line;

  // Readies are mutually exclusive, so at most one source pushes per cycle.
  always_comb begin
    push0   = s0_valid_i & s0_ready_q;
    push1   = s1_valid_i & s1_ready_q;
    push    = push0 | push1;
    pop     = (cnt_q != 2'd0) & m_ready_i;
    in_beat = push1 ? {s1_data_i, s1_sof_i, s1_eol_i} : {s0_data_i, s0_sof_i, s0_eol_i};
    in_eol  = in_beat[0];
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
  end

`ifdef AXIS_MUX_FRAME_LOCK_EN
  localparam int LCW = (LINES > 1) ? $clog2(LINES) : 1;
  logic [LCW-1:0] line_q;

  assign last_line = (line_q == LCW'(LINES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q <= '0;
    end else if (push && in_eol) begin
      line_q <= last_line ? '0 : line_q + LCW'(1);
    end
  end
`else
  assign last_line = 1'b1;
`endif

  lines_legal_a: assert property (@(posedge clk_i) LINES >= 1);

  // Ready for next cycle is derived from next occupancy, so it never sees m_ready_i combinationally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      sel_q      <= 1'b0;
      s0_ready_q <= 1'b0;
      s1_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s0_valid_i && (!s1_valid_i || !rr_q)) begin
            state_q    <= LOCK0;
            sel_q      <= 1'b0;
            s0_ready_q <= (cnt_d != 2'd2);
          end else if (s1_valid_i) begin
            state_q    <= LOCK1;
            sel_q      <= 1'b1;
            s1_ready_q <= (cnt_d != 2'd2);
          end
        end
        LOCK0: begin
          if (push0 && in_eol && last_line) begin
            state_q    <= IDLE;
            rr_q       <= 1'b1;
            s0_ready_q <= 1'b0;
          end else begin
            s0_ready_q <= (cnt_d != 2'd2);
          end
        end
        LOCK1: begin
          if (push1 && in_eol && last_line) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            s1_ready_q <= 1'b0;
          end else begin
            s1_ready_q <= (cnt_d != 2'd2);
          end
        end
        default: begin
          state_q    <= IDLE;
          s0_ready_q <= 1'b0;
          s1_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Head register always drives the output; tail only holds the overflow beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (cnt_q)
        2'd0: begin
          if (push) head_q <= in_beat;
        end
        2'd1: begin
          if (push && pop) head_q <= in_beat;
          else if (push) tail_q <= in_beat;
        end
        default: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) tail_q <= in_beat;
          end
        end
      endcase
    end
  end

  assign m_data_o   = head_q[BW-1:2];
  assign m_sof_o    = head_q[1];
  assign m_eol_o    = head_q[0];
  assign m_valid_o  = (cnt_q != 2'd0);
  assign s0_ready_o = s0_ready_q;
  assign s1_ready_o = s1_ready_q;
  assign sel_o      = sel_q;

endmodule

// File: tb/tb_axis_frame_mux.sv
// Bench for axis_frame_mux: directed steps plus random traffic, checked against a per-source line-order model.
module tb_axis_frame_mux;
  localparam int DATA_W = 16;
  localparam int LINES  = 2;
`ifdef AXIS_MUX_FRAME_LOCK_EN
  localparam int LPG = LINES;
`else
  localparam int LPG = 1;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eol;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic [DATA_W-1:0] s0_data, s1_data, m_data;
  logic s0_sof, s0_eol, s0_valid, s0_ready;
  logic s1_sof, s1_eol, s1_valid, s1_ready;
  logic m_sof, m_eol, m_valid, m_ready, sel;

  always #5 clk = ~clk;

  axis_frame_mux #(.DATA_W(DATA_W), .LINES(LINES)) dut (
    .clk_i(clk), .rst_i(rst),
    .s0_data_i(s0_data), .s0_sof_i(s0_sof), .s0_eol_i(s0_eol), .s0_valid_i(s0_valid), .s0_ready_o(s0_ready),
    .s1_data_i(s1_data), .s1_sof_i(s1_sof), .s1_eol_i(s1_eol), .s1_valid_i(s1_valid), .s1_ready_o(s1_ready),
    .m_data_o(m_data), .m_sof_o(m_sof), .m_eol_o(m_eol), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .sel_o(sel)
  );

  beat_t src_q[2][$];
  beat_t exp_q[2][$];
  bit    src_vld[2];
  logic [DATA_W-2:0] seq[2];
  int    line_src[$];
  int    sof_cyc[$];
  int    eol_cyc[$];
  int    n_chk = 0, n_pass = 0;
  int    cyc = 0, acc_in = 0, n_out = 0;
  int    mr_mode = 1, idle_pct = 0, out_cur = -1;
  bit    prev_stall = 1'b0;
  beat_t prev_ob;
  int    n0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  function automatic int pending();
    return src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size();
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
      src_vld[k] = 1'b0;
    end
    line_src.delete(); sof_cyc.delete(); eol_cyc.delete();
    out_cur = -1; acc_in = 0; n_out = 0; prev_stall = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic gen_line(input int k, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {k[0], seq[k]};
      b.sof  = (i == 0);
      b.eol  = (i == n - 1);
      src_q[k].push_back(b);
      exp_q[k].push_back(b);
      seq[k] = seq[k] + 1'b1;
    end
  endtask

  task automatic drive();
    beat_t h0, h1;
    for (int k = 0; k < 2; k++)
      if (!src_vld[k] && src_q[k].size() != 0 && $urandom_range(99) >= idle_pct) src_vld[k] = 1'b1;
    h0 = src_vld[0] ? src_q[0][0] : '0;
    h1 = src_vld[1] ? src_q[1][0] : '0;
    s0_data = h0.data; s0_sof = h0.sof; s0_eol = h0.eol; s0_valid = src_vld[0];
    s1_data = h1.data; s1_sof = h1.sof; s1_eol = h1.eol; s1_valid = src_vld[1];
    m_ready = (mr_mode == 2) ? ($urandom_range(1) == 1) : (mr_mode == 1);
  endtask

  // Output model: lines are atomic and each source's beats emerge in the order they were offered.
  task automatic model_out(input beat_t ob);
    beat_t e;
    int k;
    if (out_cur < 0) begin
      chk("line_sof", ob.sof, 1);
      out_cur = int'(ob.data[DATA_W-1]);
      line_src.push_back(out_cur);
      sof_cyc.push_back(cyc);
    end
    k = out_cur;
    chk("beat_pending", exp_q[k].size() != 0, 1);
    if (exp_q[k].size() != 0) begin
      e = exp_q[k].pop_front();
      chk("out_beat", 32'(ob), 32'(e));
    end
    n_out++;
    if (ob.eol) begin
      eol_cyc.push_back(cyc);
      out_cur = -1;
    end
  endtask

  task automatic tick();
    bit a0, a1, am, mv;
    beat_t ob;
    drive();
    #4;
    a0 = s0_valid && s0_ready;
    a1 = s1_valid && s1_ready;
    mv = m_valid;
    am = m_valid && m_ready;
    ob = {m_data, m_sof, m_eol};
    if (prev_stall) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_beat", 32'(ob), 32'(prev_ob));
    end
    if (a0) begin chk("sel_s0", sel, 0); chk("excl_ready1", s1_ready, 0); end
    if (a1) begin chk("sel_s1", sel, 1); chk("excl_ready0", s0_ready, 0); end
    @(posedge clk);
    #1;
    if (a0) begin void'(src_q[0].pop_front()); src_vld[0] = 1'b0; acc_in++; end
    if (a1) begin void'(src_q[1].pop_front()); src_vld[1] = 1'b0; acc_in++; end
    if (am) model_out(ob);
    prev_stall = mv && !am;
    prev_ob = ob;
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string tag, input int bound);
    int t = 0;
    while (pending() != 0 && t < bound) begin
      tick();
      t++;
    end
    chk({tag, "_drained"}, pending(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_m_valid"}, m_valid, 0);
    chk({p, "_m_data"}, m_data, 0);
    chk({p, "_m_sof"}, m_sof, 0);
    chk({p, "_m_eol"}, m_eol, 0);
    chk({p, "_s0_ready"}, s0_ready, 0);
    chk({p, "_s1_ready"}, s1_ready, 0);
    chk({p, "_sel"}, sel, 0);
  endtask

  task automatic chk_order(input string p, input int nlines, input int blen);
    chk({p, "_lines"}, line_src.size(), nlines);
    for (int i = 0; i < line_src.size(); i++)
      chk($sformatf("%s_src%0d", p, i), line_src[i], (i / LPG) % 2);
    for (int i = 0; i + 1 < sof_cyc.size() && i < eol_cyc.size(); i++)
      chk($sformatf("%s_gap%0d", p, i), sof_cyc[i+1] - eol_cyc[i], ((i + 1) % LPG == 0) ? 2 : 1);
    for (int i = 0; i < eol_cyc.size() && i < sof_cyc.size(); i++)
      chk($sformatf("%s_len%0d", p, i), eol_cyc[i] - sof_cyc[i], blen - 1);
  endtask

  initial begin
    rst = 1'b1;
    seq[0] = '0; seq[1] = '0;
    s0_data = '0; s0_sof = 1'b0; s0_eol = 1'b0; s0_valid = 1'b0;
    s1_data = '0; s1_sof = 1'b0; s1_eol = 1'b0; s1_valid = 1'b0;
    m_ready = 1'b0;
    prev_ob = '0;

    // Reset values
    @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single source, 4-beat line
    do_reset();
    mr_mode = 1; idle_pct = 0;
    gen_line(0, 4);
    n0 = cyc;
    drain("single", 50);
    chk("single_lines", sof_cyc.size(), 1);
    if (sof_cyc.size() != 0 && eol_cyc.size() != 0) begin
      chk("single_first_cyc", sof_cyc[0], n0 + 2);
      chk("single_last_cyc", eol_cyc[0], n0 + 5);
    end
    chk("single_sel", sel, 0);

    // Contention, 3-beat lines on both sources
    do_reset();
    for (int i = 0; i < 4; i++) begin gen_line(0, 3); gen_line(1, 3); end
    drain("cont", 200);
    chk_order("cont", 8, 3);

    // Grant across lines: per-line alternation or whole-frame hold
    do_reset();
    for (int i = 0; i < 2; i++) begin gen_line(0, 2); gen_line(1, 2); end
    drain("frm", 100);
    chk_order("frm", 4, 2);

    // Back-pressure mid-line
    do_reset();
    gen_line(0, 6);
    for (int t = 0; t < 20 && n_out < 2; t++) tick();
    mr_mode = 0;
    repeat (5) tick();
    chk("bp_outstanding", acc_in - n_out, 2);
    chk("bp_ready_low", s0_ready, 0);
    mr_mode = 1;
    drain("bp", 100);
    chk("bp_beats", n_out, 6);

    // Asynchronous reset with the buffer full, then a fresh s1 line
    do_reset();
    mr_mode = 0;
    gen_line(1, 6);
    for (int t = 0; t < 20 && (acc_in - n_out) < 2; t++) tick();
    tick();
    chk("rstm_full", acc_in - n_out, 2);
    chk("rstm_valid_before", m_valid, 1);
    chk("rstm_sel_before", sel, 1);
    #2 rst = 1'b1;
    #1;
    chk_zero("rstm");
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mr_mode = 1;
    gen_line(1, 3);
    drain("rstm", 50);
    repeat (6) tick();
    chk("rstm_beats", n_out, 3);
    chk("rstm_lines", line_src.size(), 1);

    // Random traffic with idle sources and random sink stalls
    do_reset();
    mr_mode = 2; idle_pct = 30;
    for (int i = 0; i < 12; i++)
      for (int k = 0; k < 2; k++) begin
        gen_line(k, $urandom_range(5, 1));
        gen_line(k, $urandom_range(5, 1));
      end
    drain("rand", 4000);
    chk("rand_beats", n_out, acc_in);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axis_frame_mux.md
# axis_frame_mux

Two-input, one-output arbitrating multiplexer for the `Axis` stream interface (`data`, `sof`, `eol`, `valid`, `ready`). It merges two sources onto one sink. Grant is held for a whole line, ending at the `eol` beat, so beats from different sources never interleave inside a line. Outputs are registered through a 2-entry skid buffer. It is the collecting counterpart of the stream demultiplexer used to split reorder traffic: it recombines the two split paths ahead of downstream stages.

## Interface
- `LINES`, default 8: lines per frame; used only when frame lock is compiled in (see Configuration). Legal range ≥ 1.
- `clk_i`  input  1: clock; all state updates on the rising edge.
- `rst_i`  input  1: asynchronous, active-high reset.
- `s0_axis`  `Axis.Slave`  interface width: source 0.
- `s1_axis`  `Axis.Slave`  interface width: source 1.
- `m_axis`  `Axis.Master`  interface width: merged output.
- `sel_o`  output  1: index of the currently or most recently granted source.

## Operation
- FSM states:
  - IDLE: no input ready.
  - LOCK0: `s0_axis.ready` = skid buffer not full; `s1_axis.ready` = 0.
  - LOCK1: mirror of LOCK0 for source 1.
- IDLE transitions:
  - Only `s0.valid`=1 → LOCK0.
  - Only `s1.valid`=1 → LOCK1.
  - Both valid → go to the source indicated by the round-robin pointer.
  - Neither valid → stay in IDLE.
  - `sel_o` updates on entry to LOCKx.
- Round-robin pointer: resets to "prefer s0". On each release it is set to prefer the source that was not just released.
- Release: a beat from the locked source is accepted (`valid & ready`) with `eol`=1 → IDLE, with the pointer updated.
- Accepted beats are written into the skid buffer unmodified (`data`, `sof`, `eol`). The mux never drops, duplicates or reorders beats.
- Skid buffer:
  - 2 entries.
  - `m_axis.valid` = buffer not empty; the head entry drives `m_axis`.
  - Pops on `m_axis.valid & m_axis.ready`.
  - Push and pop in the same cycle are legal at any occupancy ≤ 2 except full-with-no-pop, which cannot occur because ready is 0 when full.
- Sink back-pressure holds `m_axis.data`, `m_axis.sof`, `m_axis.eol` and `m_axis.valid` stable until the beat is accepted.
- Reset mid-line: all state clears immediately, and in-flight buffer contents are discarded. Upstream must restart at `sof`.

## Timing
- Reset values:
  - `m_axis.valid`/`data`/`sof`/`eol` = 0.
  - `s0_axis.ready` = `s1_axis.ready` = 0.
  - `sel_o` = 0, state = IDLE, pointer = prefer s0, line counter = 0.
- Arbitration latency: IDLE decides in cycle N, and the first input ready is in cycle N+1. There is one bubble cycle per line.
- Data latency: a beat accepted at input in cycle N is visible on `m_axis` in cycle N+1 if the buffer was empty.
- Throughput: 1 beat/cycle inside a line while `m_axis.ready`=1.
- Input ready is registered from buffer occupancy and has no combinational path from `m_axis.ready`.
- Valid from a non-granted source is ignored and the beat stays pending. Sources must hold their beats, per protocol.

## Configuration
- `AXIS_MUX_FRAME_LOCK_EN` defined:
  - Grant is held for a whole frame.
  - A line counter increments on each accepted `eol` beat. Release happens only on the `eol` beat that brings the count to `LINES`; the counter then returns to 0.
  - `sof` is passed through and does not affect the counter.
- `AXIS_MUX_FRAME_LOCK_EN` not defined:
  - Per-line release as described in Operation.
  - No counter logic; `LINES` is unused.

## Test plan
- Reset: assert `rst_i` asynchronously mid-line with the buffer full → all outputs 0 immediately and state IDLE. After release, a new line from s1 is accepted and the stale beats never appear.
- Single source: s0 sends a 4-beat line (D0..D3, `sof` on D0, `eol` on D3), `m_axis.ready`=1 → `m_axis` emits D0..D3 on cycles N+2..N+5 with flags intact; `sel_o`=0.
- Contention: both sources present 3-beat lines continuously → output lines alternate s0, s1, s0, s1. Each line is contiguous and there is one bubble between lines.
- Back-pressure: `m_axis.ready`=0 for 5 cycles mid-line → input ready drops after 2 accepted beats. The output beat stays stable and all beats arrive in order once ready returns.
- Frame lock (macro defined, `LINES`=2): both sources valid → s0 keeps the grant across both its lines. s1 is granted only after s0's 2nd `eol` is accepted.
- Per-line (macro undefined, same stimulus) → the grant switches to s1 after s0's first `eol`.
